// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title, countdown, race, time-out and high-score screens.
// Frame timers advance on vsync rising edges; everything lives in the pclk domain.
module game_flow_ctrl #(
  parameter int GAME_SECONDS   = 99,
  parameter int FRAMES_PER_SEC = 60,
  parameter int WAIT_FRAMES    = 180,
  parameter int TIMEOUT_FRAMES = 180,
  parameter int HISCORE_FRAMES = 600
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vs,
  input  logic       key_start,
  input  logic       key_up,
  input  logic       key_down,
  output logic       title_screen,
  output logic       wait_for_start,
  output logic       game_on,
  output logic       time_out,
  output logic       highscore,
  output logic       single_player,
  output logic       dual_player,
  output logic [2:0] screen_sel,
  output logic [6:0] time_left,
  output logic       restart
);

  localparam int WW = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam int HW = (HISCORE_FRAMES > 1) ? $clog2(HISCORE_FRAMES) : 1;

  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_FRAMES - 1);
  localparam logic [FW-1:0] FPS_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_FRAMES - 1);
  localparam logic [HW-1:0] HS_LAST   = HW'(HISCORE_FRAMES - 1);
  localparam logic [6:0]    GS        = 7'(GAME_SECONDS);

  localparam logic [2:0] S_TITLE = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_GAME  = 3'd2;
  localparam logic [2:0] S_TO    = 3'd3;
  localparam logic [2:0] S_HS    = 3'd4;

  logic          vs_q, start_q, up_q, down_q;
  logic          tick, start_p, up_p, down_p;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [HW-1:0] hs_cnt, hs_n;
  logic [2:0]    state_n;
  logic [6:0]    tl_n;
  logic          single_n, restart_n;

  assign tick    = vs & ~vs_q;
  assign start_p = key_start & ~start_q;
  assign up_p    = key_up & ~up_q;
  assign down_p  = key_down & ~down_q;

  // screen_sel doubles as the state register
  always_comb begin
    state_n   = screen_sel;
    wait_n    = wait_cnt;
    frame_n   = frame_cnt;
    to_n      = to_cnt;
    hs_n      = hs_cnt;
    tl_n      = time_left;
    single_n  = single_player;
    restart_n = 1'b0;
    case (screen_sel)
      S_TITLE: begin
        if (start_p) begin
          state_n = S_WAIT;
          wait_n  = '0;
        end else if (up_p && !down_p) begin
          single_n = 1'b1;
        end else if (down_p && !up_p) begin
          single_n = 1'b0;
        end
      end
      S_WAIT: begin
        if (tick) begin
          if (wait_cnt == WAIT_LAST) begin
            state_n = S_GAME;
            tl_n    = GS;
            frame_n = '0;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
      end
      S_GAME: begin
        if (tick) begin
          if (frame_cnt == FPS_LAST) begin
            frame_n = '0;
            if (time_left <= 7'd1) begin
              state_n = S_TO;
              tl_n    = 7'd0;
              to_n    = '0;
            end else begin
              tl_n = time_left - 7'd1;
            end
          end else begin
            frame_n = frame_cnt + 1'b1;
          end
        end
      end
      S_TO: begin
        if (tick) begin
          if (to_cnt == TO_LAST) begin
            state_n = S_HS;
            hs_n    = '0;
          end else begin
            to_n = to_cnt + 1'b1;
          end
        end
      end
      S_HS: begin
        if (start_p || (tick && hs_cnt == HS_LAST)) begin
          state_n   = S_TITLE;
          restart_n = 1'b1;
          tl_n      = GS;
        end else if (tick) begin
          hs_n = hs_cnt + 1'b1;
        end
      end
      default: state_n = S_TITLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q           <= 1'b0;
      start_q        <= 1'b0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      wait_cnt       <= '0;
      frame_cnt      <= '0;
      to_cnt         <= '0;
      hs_cnt         <= '0;
      screen_sel     <= S_TITLE;
      title_screen   <= 1'b1;
      wait_for_start <= 1'b0;
      game_on        <= 1'b0;
      time_out       <= 1'b0;
      highscore      <= 1'b0;
      single_player  <= 1'b1;
      dual_player    <= 1'b0;
      time_left      <= GS;
      restart        <= 1'b0;
    end else begin
      vs_q           <= vs;
      start_q        <= key_start;
      up_q           <= key_up;
      down_q         <= key_down;
      wait_cnt       <= wait_n;
      frame_cnt      <= frame_n;
      to_cnt         <= to_n;
      hs_cnt         <= hs_n;
      screen_sel     <= state_n;
      title_screen   <= (state_n == S_TITLE);
      wait_for_start <= (state_n == S_WAIT);
      game_on        <= (state_n == S_GAME);
      time_out       <= (state_n == S_TO);
      highscore      <= (state_n == S_HS);
      single_player  <= single_n;
      dual_player    <= ~single_n;
      time_left      <= tl_n;
      restart        <= restart_n;
    end
  end

endmodule
